// File: rtl/axis_msg_len_tracker_pkg.sv
// Shared types for the AXI-Stream message length tracker: the record
// layout at default widths, the channel-field width and the counting-mode encodings.
package msg_len_pkg;

  localparam int DEF_NUM_CHANNELS = 4;
  localparam int DEF_COUNT_W      = 16;
  localparam int CHAN_W           = $clog2(DEF_NUM_CHANNELS);

  typedef enum logic {
    COUNT_BEATS = 1'b0,
    COUNT_BYTES = 1'b1
  } count_mode_e;

  typedef struct packed {
    logic [CHAN_W-1:0]      chan;
    logic [DEF_COUNT_W-1:0] len;
    logic                   forced;
    logic                   sat;
  } msg_rec_t;

endpackage

// File: rtl/axis_msg_len_tracker_if.sv
// Bundles the monitored AXI-Stream sideband and the record read port.
// The master side drives the stream and consumes records; the slave side is the tracker.
interface axis_msg_len_tracker_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_BYTES   = 8,
  parameter int COUNT_W      = 16
);

  localparam int CHAN_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic                  s_tvalid;
  logic                  s_tready;
  logic                  s_tlast;
  logic [DATA_BYTES-1:0] s_tkeep;
  logic [CHAN_W-1:0]     s_tdest;

  logic                  rec_valid;
  logic                  rec_ready;
  logic [CHAN_W-1:0]     rec_chan;
  logic [COUNT_W-1:0]    rec_len;
  logic                  rec_forced;
  logic                  rec_sat;

  modport master (
    output s_tvalid, s_tready, s_tlast, s_tkeep, s_tdest, rec_ready,
    input  rec_valid, rec_chan, rec_len, rec_forced, rec_sat
  );

  modport slave (
    input  s_tvalid, s_tready, s_tlast, s_tkeep, s_tdest, rec_ready,
    output rec_valid, rec_chan, rec_len, rec_forced, rec_sat
  );

endinterface

// File: rtl/axis_msg_len_tracker_fifo.sv
// First-word-fall-through record FIFO. A push into a full FIFO is taken only
// when a pop happens in the same cycle; clear empties it synchronously.
module msg_rec_fifo
  import msg_len_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = msg_rec_t
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic push,
  input  T     wr_data,
  input  logic pop,
  output T     rd_data,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T              mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          wr_en;
  logic          rd_en;

  // Pointers carry one wrap bit so full and empty are distinguishable
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  assign rd_data = empty ? T'('0) : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= T'('0);
    end else if (wr_en && !clear) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/axis_msg_len_tracker.sv
// Passive AXI-Stream monitor: per-destination message length counters (beats or
// bytes), closing on tlast or a programmable maximum, with records queued in a FIFO.
module axis_msg_len_tracker
  import msg_len_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_BYTES   = 8,
  parameter int COUNT_W      = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  axis_msg_len_tracker_if.slave bus,
  input  logic                 clear,
  input  logic                 count_mode,
  input  logic [COUNT_W-1:0]   max_len,
  output logic [7:0]           drop_count,
  output logic                 overflow
);

  localparam int TDEST_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  typedef struct packed {
    logic [TDEST_W-1:0] chan;
    logic [COUNT_W-1:0] len;
    logic               forced;
    logic               sat;
  } rec_t;

  logic [COUNT_W-1:0] cnt [NUM_CHANNELS];
  count_mode_e        mode;
  logic               chan_ok;
  logic               beat;
  logic [COUNT_W:0]   inc;
  logic [COUNT_W:0]   cur;
  logic [COUNT_W:0]   sum;
  logic               sat;
  logic [COUNT_W-1:0] len;
  logic               limit_hit;
  logic               close;
  logic               forced;
  logic               push;
  logic               pop;
  logic               dropped;
  logic               fifo_full;
  logic               fifo_empty;
  rec_t               wr_rec;
  rec_t               head;

  assign mode    = count_mode_e'(count_mode);
  assign chan_ok = ({1'b0, bus.s_tdest} < (TDEST_W+1)'(NUM_CHANNELS));
  assign beat    = bus.s_tvalid && bus.s_tready && chan_ok;

  // Byte mode adds the popcount of tkeep; an all-zero keep still forms a beat
  always_comb begin
    inc = '0;
    if (mode == COUNT_BYTES) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        inc = inc + {{COUNT_W{1'b0}}, bus.s_tkeep[i]};
      end
    end else begin
      inc = {{COUNT_W{1'b0}}, 1'b1};
    end
  end

  assign cur       = chan_ok ? {1'b0, cnt[bus.s_tdest]} : '0;
  assign sum       = cur + inc;
  assign sat       = sum[COUNT_W];
  assign len       = sat ? '1 : sum[COUNT_W-1:0];
  assign limit_hit = (max_len != '0) && (sum >= {1'b0, max_len});
  assign close     = beat && (bus.s_tlast || limit_hit);
  assign forced    = close && !bus.s_tlast;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NUM_CHANNELS; c++) cnt[c] <= '0;
    end else if (clear) begin
      for (int c = 0; c < NUM_CHANNELS; c++) cnt[c] <= '0;
    end else if (beat) begin
      cnt[bus.s_tdest] <= close ? '0 : len;
    end
  end

  assign push    = close && !clear;
  assign pop     = bus.rec_valid && bus.rec_ready;
  assign dropped = push && fifo_full && !pop;

  always_comb begin
    wr_rec        = '0;
    wr_rec.chan   = bus.s_tdest;
    wr_rec.len    = len;
    wr_rec.forced = forced;
    wr_rec.sat    = sat;
  end

  msg_rec_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (rec_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .push    (push),
    .wr_data (wr_rec),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bus.rec_valid  = !fifo_empty;
  assign bus.rec_chan   = head.chan;
  assign bus.rec_len    = head.len;
  assign bus.rec_forced = head.forced;
  assign bus.rec_sat    = head.sat;

  // Loss accounting saturates so a long stall cannot wrap back to a small number
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (clear) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (dropped) begin
      if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_msg_len_tracker.sv
// Self-checking bench for axis_msg_len_tracker: a vector table for the main
// counting cases plus hand sequences for FIFO overflow, clear, reset and saturation.
module tb_axis_msg_len_tracker;

  typedef struct {
    int  chan;
    int  len;
    bit  forced;
    bit  sat;
  } exp_t;

  typedef struct {
    int         dest;
    logic [7:0] keep;
    bit         last;
    bit         rdy;
    bit         mode;
    int         maxl;
    bit         push;
    int         len;
    bit         forced;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        count_mode;
  logic [15:0] max_len;
  logic [7:0]  drop_count;
  logic        overflow;
  logic        clear_s;
  logic        mode_s;
  logic [3:0]  maxl_s;
  logic [7:0]  drop_s;
  logic        ovf_s;

  int   total;
  int   bad;
  exp_t sb_main[$];
  exp_t sb_small[$];
  vec_t vecs[$];

  axis_msg_len_tracker_if #(.NUM_CHANNELS(4), .DATA_BYTES(8), .COUNT_W(16)) bus_main();
  axis_msg_len_tracker_if #(.NUM_CHANNELS(4), .DATA_BYTES(8), .COUNT_W(4))  bus_small();

  axis_msg_len_tracker #(
    .NUM_CHANNELS(4), .DATA_BYTES(8), .COUNT_W(16), .FIFO_DEPTH(8)
  ) dut_main (
    .clk        (clk),
    .rst        (rst_n),
    .bus        (bus_main),
    .clear      (clear),
    .count_mode (count_mode),
    .max_len    (max_len),
    .drop_count (drop_count),
    .overflow   (overflow)
  );

  axis_msg_len_tracker #(
    .NUM_CHANNELS(4), .DATA_BYTES(8), .COUNT_W(4), .FIFO_DEPTH(8)
  ) dut_small (
    .clk        (clk),
    .rst        (rst_n),
    .bus        (bus_small),
    .clear      (clear_s),
    .count_mode (mode_s),
    .max_len    (maxl_s),
    .drop_count (drop_s),
    .overflow   (ovf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input int dest, input logic [7:0] keep, input bit last, input bit rdy,
                         input bit mode, input int maxl, input bit push, input int len,
                         input bit forced);
    vec_t v;
    v.dest = dest; v.keep = keep; v.last = last; v.rdy = rdy; v.mode = mode;
    v.maxl = maxl; v.push = push; v.len = len; v.forced = forced;
    vecs.push_back(v);
  endtask

  task automatic apply_stimulus(input int dest, input logic [7:0] keep, input bit last,
                                input bit rdy, input bit mode, input int maxl);
    bus_main.s_tvalid = 1'b1;
    bus_main.s_tready = rdy;
    bus_main.s_tdest  = 2'(dest);
    bus_main.s_tkeep  = keep;
    bus_main.s_tlast  = last;
    count_mode        = mode;
    max_len           = 16'(maxl);
    sync();
    bus_main.s_tvalid = 1'b0;
    bus_main.s_tlast  = 1'b0;
  endtask

  task automatic apply_small(input int dest, input logic [7:0] keep, input bit last);
    bus_small.s_tvalid = 1'b1;
    bus_small.s_tready = 1'b1;
    bus_small.s_tdest  = 2'(dest);
    bus_small.s_tkeep  = keep;
    bus_small.s_tlast  = last;
    sync();
    bus_small.s_tvalid = 1'b0;
    bus_small.s_tlast  = 1'b0;
  endtask

  task automatic push_exp_main(input int chan, input int len, input bit forced, input bit sat);
    exp_t e;
    e.chan = chan; e.len = len; e.forced = forced; e.sat = sat;
    sb_main.push_back(e);
  endtask

  task automatic push_exp_small(input int chan, input int len, input bit forced, input bit sat);
    exp_t e;
    e.chan = chan; e.len = len; e.forced = forced; e.sat = sat;
    sb_small.push_back(e);
  endtask

  // Every popped record is compared against the oldest expectation
  task automatic monitor_main();
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus_main.rec_valid && bus_main.rec_ready) begin
        check_output("main_record_expected", int'(sb_main.size() != 0), 1);
        if (sb_main.size() != 0) begin
          e = sb_main.pop_front();
          check_output("main_chan",   int'(bus_main.rec_chan),   e.chan);
          check_output("main_len",    int'(bus_main.rec_len),    e.len);
          check_output("main_forced", int'(bus_main.rec_forced), int'(e.forced));
          check_output("main_sat",    int'(bus_main.rec_sat),    int'(e.sat));
        end
      end
    end
  endtask

  task automatic monitor_small();
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus_small.rec_valid && bus_small.rec_ready) begin
        check_output("small_record_expected", int'(sb_small.size() != 0), 1);
        if (sb_small.size() != 0) begin
          e = sb_small.pop_front();
          check_output("small_chan",   int'(bus_small.rec_chan),   e.chan);
          check_output("small_len",    int'(bus_small.rec_len),    e.len);
          check_output("small_forced", int'(bus_small.rec_forced), int'(e.forced));
          check_output("small_sat",    int'(bus_small.rec_sat),    int'(e.sat));
        end
      end
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 64; i++) begin
      if (sb_main.size() == 0 && sb_small.size() == 0) break;
      @(negedge clk);
    end
    check_output(name, sb_main.size() + sb_small.size(), 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    clear = 1'b0; count_mode = 1'b0; max_len = '0;
    clear_s = 1'b0; mode_s = 1'b1; maxl_s = '0;
    bus_main.s_tvalid = 1'b0; bus_main.s_tready = 1'b0; bus_main.s_tlast = 1'b0;
    bus_main.s_tkeep = '0; bus_main.s_tdest = '0; bus_main.rec_ready = 1'b1;
    bus_small.s_tvalid = 1'b0; bus_small.s_tready = 1'b0; bus_small.s_tlast = 1'b0;
    bus_small.s_tkeep = '0; bus_small.s_tdest = '0; bus_small.rec_ready = 1'b1;

    // vec: dest keep last rdy mode maxl | push len forced
    add_vec(2, 8'hFF, 0, 1, 0, 0, 0, 0, 0);
    add_vec(2, 8'hFF, 0, 1, 0, 0, 0, 0, 0);
    add_vec(2, 8'hFF, 1, 0, 0, 0, 0, 0, 0);
    add_vec(2, 8'hFF, 0, 1, 0, 0, 0, 0, 0);
    add_vec(2, 8'hFF, 0, 1, 0, 0, 0, 0, 0);
    add_vec(2, 8'hFF, 1, 1, 0, 0, 1, 5, 0);
    add_vec(0, 8'hFF, 1, 1, 0, 0, 1, 1, 0);
    add_vec(1, 8'hFF, 1, 1, 0, 0, 1, 1, 0);
    add_vec(3, 8'hFF, 1, 1, 0, 0, 1, 1, 0);
    add_vec(1, 8'hFF, 0, 1, 1, 0, 0, 0, 0);
    add_vec(3, 8'h01, 0, 1, 1, 0, 0, 0, 0);
    add_vec(1, 8'hFF, 0, 1, 1, 0, 0, 0, 0);
    add_vec(3, 8'h03, 1, 1, 1, 0, 1, 3, 0);
    add_vec(1, 8'h0F, 1, 1, 1, 0, 1, 20, 0);
    add_vec(3, 8'h00, 0, 1, 1, 0, 0, 0, 0);
    add_vec(3, 8'h00, 1, 1, 1, 0, 1, 0, 0);
    add_vec(2, 8'hFF, 0, 1, 0, 0, 0, 0, 0);
    add_vec(2, 8'h07, 1, 1, 1, 0, 1, 4, 0);
    for (int b = 0; b < 3; b++) add_vec(1, 8'hFF, 0, 1, 0, 0, 0, 0, 0);
    add_vec(1, 8'hFF, 0, 1, 0, 2, 1, 4, 1);
    for (int b = 1; b <= 10; b++) begin
      add_vec(0, 8'hFF, b == 10, 1, 0, 4, (b % 4 == 0) || (b == 10), (b == 10) ? 2 : 4, b != 10);
    end

    fork
      monitor_main();
      monitor_small();
    join_none

    repeat (2) @(negedge clk);
    check_output("reset_rec_valid",  int'(bus_main.rec_valid), 0);
    check_output("reset_rec_len",    int'(bus_main.rec_len), 0);
    check_output("reset_rec_chan",   int'(bus_main.rec_chan), 0);
    check_output("reset_drop_count", int'(drop_count), 0);
    check_output("reset_overflow",   int'(overflow), 0);
    check_output("reset_small_valid", int'(bus_small.rec_valid), 0);
    sync();
    rst_n = 1'b1;
    sync();

    foreach (vecs[k]) begin
      if (vecs[k].push) push_exp_main(vecs[k].dest, vecs[k].len, vecs[k].forced, 1'b0);
      apply_stimulus(vecs[k].dest, vecs[k].keep, vecs[k].last, vecs[k].rdy, vecs[k].mode, vecs[k].maxl);
    end
    drain("drain_table");

    // Record must appear exactly one cycle after the closing beat
    sync();
    count_mode = 1'b0; max_len = '0;
    bus_main.s_tvalid = 1'b1; bus_main.s_tready = 1'b1; bus_main.s_tdest = 2'd3;
    bus_main.s_tlast = 1'b1; bus_main.s_tkeep = 8'hFF;
    push_exp_main(3, 1, 0, 0);
    @(negedge clk);
    check_output("latency_before", int'(bus_main.rec_valid), 0);
    @(posedge clk); #1;
    bus_main.s_tvalid = 1'b0; bus_main.s_tlast = 1'b0;
    @(negedge clk);
    check_output("latency_after", int'(bus_main.rec_valid), 1);
    drain("drain_latency");

    sync();
    apply_small(0, 8'hFF, 0);
    apply_small(0, 8'hFF, 0);
    apply_small(0, 8'hFF, 0);
    push_exp_small(0, 15, 0, 1);
    apply_small(0, 8'hFF, 1);
    apply_small(1, 8'h7F, 0);
    push_exp_small(1, 15, 0, 0);
    apply_small(1, 8'hFF, 1);
    drain("drain_small");

    // Overflow: eight records fit, the next three are lost
    sync();
    bus_main.rec_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (i < 8) push_exp_main(i % 4, (i % 8) + 1, 0, 0);
      apply_stimulus(i % 4, 8'((1 << ((i % 8) + 1)) - 1), 1, 1, 1, 0);
    end
    repeat (2) sync();
    @(negedge clk);
    check_output("ovf_drop_count", int'(drop_count), 3);
    check_output("ovf_overflow",   int'(overflow), 1);
    check_output("ovf_hold_valid", int'(bus_main.rec_valid), 1);
    check_output("ovf_hold_chan",  int'(bus_main.rec_chan), 0);
    check_output("ovf_hold_len",   int'(bus_main.rec_len), 1);
    @(posedge clk); #1;
    bus_main.rec_ready = 1'b1;
    push_exp_main(1, 4, 0, 0);
    apply_stimulus(1, 8'h0F, 1, 1, 1, 0);
    @(negedge clk);
    check_output("full_pushpop_drop", int'(drop_count), 3);
    drain("drain_overflow");

    // Clear with a pending record, a partial message and a closing beat
    sync();
    bus_main.rec_ready = 1'b0;
    apply_stimulus(0, 8'hFF, 1, 1, 0, 0);
    apply_stimulus(2, 8'hFF, 0, 1, 0, 0);
    apply_stimulus(2, 8'hFF, 0, 1, 0, 0);
    clear = 1'b1;
    apply_stimulus(2, 8'hFF, 1, 1, 0, 0);
    clear = 1'b0;
    @(negedge clk);
    check_output("clear_rec_valid",  int'(bus_main.rec_valid), 0);
    check_output("clear_drop_count", int'(drop_count), 0);
    check_output("clear_overflow",   int'(overflow), 0);
    @(posedge clk); #1;
    bus_main.rec_ready = 1'b1;
    apply_stimulus(2, 8'hFF, 0, 1, 0, 0);
    apply_stimulus(2, 8'hFF, 0, 1, 0, 0);
    push_exp_main(2, 3, 0, 0);
    apply_stimulus(2, 8'hFF, 1, 1, 0, 0);
    drain("drain_clear");

    // Reset mid-message discards the partial count
    sync();
    apply_stimulus(1, 8'hFF, 0, 1, 0, 0);
    apply_stimulus(1, 8'hFF, 0, 1, 0, 0);
    rst_n = 1'b0;
    sync();
    check_output("midreset_rec_valid", int'(bus_main.rec_valid), 0);
    rst_n = 1'b1;
    sync();
    push_exp_main(1, 1, 0, 0);
    apply_stimulus(1, 8'hFF, 1, 1, 0, 0);
    drain("drain_reset");

    repeat (4) @(negedge clk);
    check_output("final_main_idle",  int'(bus_main.rec_valid), 0);
    check_output("final_small_idle", int'(bus_small.rec_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
